// File: rtl/psum_acc_buf.sv
// Ping-pong PSUM accumulation buffer: raster-order words accumulate into one bank while the pool stage reads the other.
// Completed patches become readable the cycle after their last word; pe_rdy drops only when both banks hold FULL patches.
module psum_acc_buf #(
   parameter int NUM_LANE   = 16,
   parameter int PSUM_WIDTH = 23,
   parameter int LEN        = 14,
   parameter int ADDR_W     = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [7:0]                     cfg_num_acc,
   input  logic                           pe_val,
   output logic                           pe_rdy,
   input  logic [PSUM_WIDTH*NUM_LANE-1:0] pe_dat,
   output logic                           pool_val,
   input  logic                           pool_en_rd,
   input  logic [ADDR_W-1:0]              pool_addr_rd,
   output logic [PSUM_WIDTH*NUM_LANE-1:0] pool_dat,
   input  logic                           pool_done,
   output logic                           busy
);

   localparam int DEPTH = LEN * LEN;
   localparam int CW    = $clog2(DEPTH);
   localparam int DW    = PSUM_WIDTH * NUM_LANE;

   typedef enum logic [1:0] {EMPTY = 2'd0, ACC = 2'd1, FULL = 2'd2} bank_st_t;

   bank_st_t             st [2];
   logic                 wr_bank;
   logic                 rd_bank;
   logic [CW-1:0]        wcnt;
   logic [7:0]           pcnt;
   logic [7:0]           num_acc_q;
   logic [DW-1:0]        mem [2][DEPTH];

   logic [DW-1:0]        stored;
   logic [DW-1:0]        wdat;
   logic [PSUM_WIDTH:0]  lane_sum [NUM_LANE];
   logic                 xfer;
   logic                 first;
   logic                 last_word;
   logic                 done_patch;
   logic [7:0]           num_acc_eff;
   logic                 in_range;

   assign pe_rdy    = (st[wr_bank] != FULL);
   assign pool_val  = (st[rd_bank] == FULL);
   assign busy      = (st[0] != EMPTY) || (st[1] != EMPTY);
   assign xfer      = pe_val && pe_rdy;
   assign first     = (wcnt == '0) && (pcnt == 8'd0);
   assign last_word = (wcnt == CW'(DEPTH - 1));
   // The pass count is taken live on the first word and held for the rest of the patch.
   assign num_acc_eff = first ? ((cfg_num_acc == 8'd0) ? 8'd1 : cfg_num_acc) : num_acc_q;
   assign done_patch  = xfer && last_word && (pcnt == num_acc_eff - 8'd1);
   assign in_range    = (32'(pool_addr_rd) < DEPTH);
   assign stored      = mem[wr_bank][wcnt];

   always_comb begin
      wdat = pe_dat;
      for (int i = 0; i < NUM_LANE; i++) begin
         lane_sum[i] = {stored[PSUM_WIDTH*i+PSUM_WIDTH-1], stored[PSUM_WIDTH*i +: PSUM_WIDTH]}
                     + {pe_dat[PSUM_WIDTH*i+PSUM_WIDTH-1], pe_dat[PSUM_WIDTH*i +: PSUM_WIDTH]};
         if (pcnt != 8'd0) begin
            // Overflow shows as disagreement between the guard bit and the lane sign bit.
            if (lane_sum[i][PSUM_WIDTH] != lane_sum[i][PSUM_WIDTH-1])
               wdat[PSUM_WIDTH*i +: PSUM_WIDTH] = {lane_sum[i][PSUM_WIDTH],
                                                   {(PSUM_WIDTH-1){~lane_sum[i][PSUM_WIDTH]}}};
            else
               wdat[PSUM_WIDTH*i +: PSUM_WIDTH] = lane_sum[i][PSUM_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (xfer)
         mem[wr_bank][wcnt] <= wdat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st[0]     <= EMPTY;
         st[1]     <= EMPTY;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         wcnt      <= '0;
         pcnt      <= 8'd0;
         num_acc_q <= 8'd1;
         pool_dat  <= '0;
      end else begin
         if (pool_val && pool_en_rd)
            pool_dat <= in_range ? mem[rd_bank][pool_addr_rd[CW-1:0]] : '0;
         if (xfer) begin
            if (st[wr_bank] == EMPTY)
               st[wr_bank] <= ACC;
            if (first)
               num_acc_q <= num_acc_eff;
            if (done_patch) begin
               st[wr_bank] <= FULL;
               wcnt        <= '0;
               pcnt        <= 8'd0;
               wr_bank     <= ~wr_bank;
            end else if (last_word) begin
               wcnt <= '0;
               pcnt <= pcnt + 8'd1;
            end else begin
               wcnt <= wcnt + CW'(1);
            end
         end
         // A full rd_bank blocks writes to it, so this never collides with the completion above.
         if (pool_val && pool_done) begin
            st[rd_bank] <= EMPTY;
            rd_bank     <= ~rd_bank;
         end
      end
   end

endmodule
